// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer in front of a dual-port RAM; read data is tagged back to its requester.
// Build option: define ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module ram_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_ram_we,
  output logic              o_ram_re,
  output logic [ADDR_W-1:0] o_ram_wr_addr,
  output logic [ADDR_W-1:0] o_ram_rd_addr,
  output logic [DATA_W-1:0] o_ram_din,
  input  logic [DATA_W-1:0] i_ram_dout
);

  logic              r_ack0, r_ack1;
  logic              r_ram_we, r_ram_re;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic [DATA_W-1:0] r_din;
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_id;

  logic              w_elig0, w_elig1, w_pick1, w_grant;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // A requester acked this cycle is still holding its old fields, so it sits out one decision.
  assign w_elig0 = i_req0 & ~r_ack0;
  assign w_elig1 = i_req1 & ~r_ack1;
  assign w_grant = w_elig0 | w_elig1;

`ifdef ARB_FIXED_PRIORITY_EN
  assign w_pick1 = w_elig1 & ~w_elig0;
`else
  logic r_last;
  assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last);
`endif

  assign w_we    = w_pick1 ? i_we1    : i_we0;
  assign w_addr  = w_pick1 ? i_addr1  : i_addr0;
  assign w_wdata = w_pick1 ? i_wdata1 : i_wdata0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_ram_we  <= 1'b0;
      r_ram_re  <= 1'b0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_din     <= '0;
      r_tag_vld <= '0;
      r_tag_id  <= '0;
`ifdef ARB_FIXED_PRIORITY_EN
`else
      r_last    <= 1'b1;
`endif
    end else begin
      r_ack0   <= w_grant & ~w_pick1;
      r_ack1   <= w_pick1;
      r_ram_we <= w_grant & w_we;
      r_ram_re <= w_grant & ~w_we;
      if (w_grant && w_we) begin
        r_wr_addr <= w_addr;
        r_din     <= w_wdata;
      end
      if (w_grant && !w_we) r_rd_addr <= w_addr;
      // Stage 0 is loaded from the issue cycle; the last stage lines up with valid RAM data.
      r_tag_vld[0] <= r_ram_re;
      r_tag_id[0]  <= r_ack1;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
`ifdef ARB_FIXED_PRIORITY_EN
`else
      if (w_grant) r_last <= w_pick1;
`endif
    end
  end

  assign o_ack0        = r_ack0;
  assign o_ack1        = r_ack1;
  assign o_ram_we      = r_ram_we;
  assign o_ram_re      = r_ram_re;
  assign o_ram_wr_addr = r_wr_addr;
  assign o_ram_rd_addr = r_rd_addr;
  assign o_ram_din     = r_din;
  assign o_rvalid0     = r_tag_vld[RD_LAT-1] & ~r_tag_id[RD_LAT-1];
  assign o_rvalid1     = r_tag_vld[RD_LAT-1] &  r_tag_id[RD_LAT-1];
  assign o_rdata0      = i_ram_dout;
  assign o_rdata1      = i_ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_ram_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int RL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    req, we;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wd [2];
  logic          ack0, ack1, rv0, rv1, ram_we, ram_re;
  logic [DW-1:0] rd0, rd1, din, dout;
  logic [AW-1:0] wa, ra;

  ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req[0]), .i_req1(req[1]), .i_we0(we[0]), .i_we1(we[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_wdata0(wd[0]), .i_wdata1(wd[1]),
    .o_ack0(ack0), .o_ack1(ack1), .o_rvalid0(rv0), .o_rvalid1(rv1),
    .o_rdata0(rd0), .o_rdata1(rd1), .o_ram_we(ram_we), .o_ram_re(ram_re),
    .o_ram_wr_addr(wa), .o_ram_rd_addr(ra), .o_ram_din(din), .i_ram_dout(dout)
  );

  // RAM with RL-cycle read latency
  logic [DW-1:0] mem [8];
  logic [DW-1:0] rp [RL];
  always @(posedge clk) begin
    if (ram_we) mem[wa] <= din;
    if (ram_re) rp[0] <= mem[ra];
    for (int i = 1; i < RL; i++) rp[i] <= rp[i-1];
  end
  assign dout = rp[RL-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction-level reference: expected outputs for the current cycle plus pending reads.
  bit [1:0]    m_ack;
  bit          m_we, m_re;
  bit [AW-1:0] m_wa, m_ra;
  bit [DW-1:0] m_din;
  int          m_last;
  bit [DW-1:0] m_mem [8];
  bit          m_known [8];
  typedef struct { int due; int id; bit [DW-1:0] data; bit known; } rd_t;
  rd_t rq[$];

  task automatic model_edge();
    bit e0, e1;
    int win;
    if (rst) begin
      m_ack = '0; m_we = 0; m_re = 0; m_wa = '0; m_ra = '0; m_din = '0;
      m_last = 1;
      rq.delete();
    end else begin
      e0 = req[0] && !m_ack[0];
      e1 = req[1] && !m_ack[1];
      win = -1;
      if (e0 && e1) win = 1 - m_last;
      else if (e0)  win = 0;
      else if (e1)  win = 1;
      m_ack = '0; m_we = 0; m_re = 0;
      if (win >= 0) begin
        m_ack[win] = 1'b1;
        m_last = win;
        if (we[win]) begin
          m_we = 1; m_wa = addr[win]; m_din = wd[win];
          m_mem[addr[win]] = wd[win];
          m_known[addr[win]] = 1;
        end else begin
          m_re = 1; m_ra = addr[win];
          rq.push_back(rd_t'{cyc + 1 + RL, win, m_mem[addr[win]], m_known[addr[win]]});
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 2'b00;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1; req = 2'b00;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req = 2'b11; we = 2'b00; addr[0] = 3'd0; addr[1] = 3'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({ack0, ack1, rv0, rv1, ram_we, ram_re} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctl cyc=%0d act=%b exp=000000", cyc, {ack0, ack1, rv0, rv1, ram_we, ram_re});
      end
      checks++;
      if (wa !== 3'd0 || ra !== 3'd0 || din !== 16'd0) begin
        errors++;
        $display("FAIL reset_data cyc=%0d wa=%0d ra=%0d din=%h exp 0", cyc, wa, ra, din);
      end
    end
    rst = 0;
    tick();
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || ram_re !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_ack ack0=%b ack1=%b re=%b exp 1 0 1", ack0, ack1, ram_re);
    end
    idle(RL + 2);
  endtask

  task automatic test_single_write();
    req = 2'b01; we[0] = 1; addr[0] = 3'd3; wd[0] = 16'h00A5;
    tick();
    checks++;
    if (ram_we !== 1'b1 || wa !== 3'd3 || din !== 16'h00A5 || ram_re !== 1'b0) begin
      errors++;
      $display("FAIL single_write we=%b wa=%0d din=%h re=%b exp 1 3 00a5 0", ram_we, wa, din, ram_re);
    end
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      errors++;
      $display("FAIL single_write_ack ack0=%b ack1=%b exp 1 0", ack0, ack1);
    end
    req = 2'b00;
    tick();
    checks++;
    if (ack0 !== 1'b0 || ram_we !== 1'b0 || wa !== 3'd3 || din !== 16'h00A5) begin
      errors++;
      $display("FAIL single_write_hold ack0=%b we=%b wa=%0d din=%h exp 0 0 3 00a5", ack0, ram_we, wa, din);
    end
  endtask

  task automatic test_write_read();
    req = 2'b10; we[1] = 1; addr[1] = 3'd5; wd[1] = 16'h1234;
    tick();
    checks++;
    if (ack1 !== 1'b1 || ram_we !== 1'b1 || wa !== 3'd5) begin
      errors++;
      $display("FAIL wr_issue ack1=%b we=%b wa=%0d exp 1 1 5", ack1, ram_we, wa);
    end
    req = 2'b01; we[0] = 0; addr[0] = 3'd5;
    tick();
    checks++;
    if (ack0 !== 1'b1 || ram_re !== 1'b1 || ra !== 3'd5) begin
      errors++;
      $display("FAIL rd_issue ack0=%b re=%b ra=%0d exp 1 1 5", ack0, ram_re, ra);
    end
    req = 2'b00;
    for (int j = 1; j <= RL + 1; j++) begin
      tick();
      checks++;
      if (rv0 !== (j == RL) || rv1 !== 1'b0) begin
        errors++;
        $display("FAIL rd_return j=%0d rv0=%b rv1=%b exp %b 0", j, rv0, rv1, (j == RL));
      end
      if (j == RL) begin
        checks++;
        if (rd0 !== 16'h1234) begin
          errors++;
          $display("FAIL rd_data act=%h exp=1234", rd0);
        end
      end
    end
  endtask

  task automatic test_contention();
    bit e0;
    do_reset();
    req = 2'b11; we = 2'b00; addr[0] = 3'd1; addr[1] = 3'd2;
    for (int k = 1; k <= 8 + RL; k++) begin
      tick();
      if (k <= 8) begin
        checks++;
        if (ack0 !== (k % 2 == 1) || ack1 !== (k % 2 == 0) || ram_re !== 1'b1 ||
            ra !== ((k % 2 == 1) ? 3'd1 : 3'd2)) begin
          errors++;
          $display("FAIL contention k=%0d ack0=%b ack1=%b re=%b ra=%0d", k, ack0, ack1, ram_re, ra);
        end
      end
      if (k == 8) req = 2'b00;
      e0 = (k > RL) && ((k - RL) % 2 == 1);
      checks++;
      if (rv0 !== e0 || rv1 !== ((k > RL) && !e0)) begin
        errors++;
        $display("FAIL contention_rv k=%0d rv0=%b rv1=%b exp %b %b", k, rv0, rv1, e0, (k > RL) && !e0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] cur;
    req = 2'b01; we[0] = 0; cur = 3'd4; addr[0] = cur;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (ack0 !== (k % 2 == 1) || ram_re !== (k % 2 == 1) || ((k % 2 == 1) && ra !== cur)) begin
        errors++;
        $display("FAIL back_to_back k=%0d ack0=%b re=%b ra=%0d exp_ra=%0d", k, ack0, ram_re, ra, cur);
      end
      if (k % 2 == 1) begin
        cur = cur + 3'd1;
        addr[0] = cur;
      end
      if (k == 6) req = 2'b00;
    end
    idle(RL + 1);
  endtask

  task automatic test_reset_pending();
    req = 2'b01; we[0] = 0; addr[0] = 3'd5;
    tick();
    checks++;
    if (ack0 !== 1'b1 || ram_re !== 1'b1) begin
      errors++;
      $display("FAIL rstpend_issue ack0=%b re=%b exp 1 1", ack0, ram_re);
    end
    req = 2'b00; rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({ack0, ack1, ram_we, ram_re} !== 4'b0) begin
      errors++;
      $display("FAIL rstpend_clear act=%b exp=0000", {ack0, ack1, ram_we, ram_re});
    end
    for (int j = 0; j < RL + 3; j++) begin
      tick();
      checks++;
      if (rv0 !== 1'b0 || rv1 !== 1'b0) begin
        errors++;
        $display("FAIL rstpend_rv j=%0d rv0=%b rv1=%b exp 0 0", j, rv0, rv1);
      end
    end
  endtask

  task automatic test_random();
    bit ev0, ev1, ek;
    bit [DW-1:0] ed;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req[r] || m_ack[r]) begin
          if ($urandom_range(0, 2) != 0) begin
            req[r]  = 1'b1;
            we[r]   = $urandom_range(0, 1) == 1;
            addr[r] = AW'($urandom_range(0, 7));
            wd[r]   = DW'($urandom);
          end else begin
            req[r] = 1'b0;
          end
        end
      end
      rst = ($urandom_range(0, 59) == 0);
      tick();
      checks++;
      if (ack0 !== m_ack[0] || ack1 !== m_ack[1]) begin
        errors++;
        $display("FAIL rand_ack cyc=%0d act=%b%b exp=%b%b", cyc, ack1, ack0, m_ack[1], m_ack[0]);
      end
      checks++;
      if (ram_we !== m_we || ram_re !== m_re || wa !== m_wa || ra !== m_ra || din !== m_din) begin
        errors++;
        $display("FAIL rand_ram cyc=%0d we=%b re=%b wa=%0d ra=%0d din=%h exp %b %b %0d %0d %h",
                 cyc, ram_we, ram_re, wa, ra, din, m_we, m_re, m_wa, m_ra, m_din);
      end
      ev0 = 0; ev1 = 0; ek = 0; ed = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        ev0 = (rq[0].id == 0); ev1 = (rq[0].id == 1);
        ek = rq[0].known; ed = rq[0].data;
        void'(rq.pop_front());
      end
      checks++;
      if (rv0 !== ev0 || rv1 !== ev1) begin
        errors++;
        $display("FAIL rand_rvalid cyc=%0d act=%b%b exp=%b%b", cyc, rv1, rv0, ev1, ev0);
      end
      if (ek) begin
        checks++;
        if ((ev0 ? rd0 : rd1) !== ed) begin
          errors++;
          $display("FAIL rand_rdata cyc=%0d act=%h exp=%h", cyc, ev0 ? rd0 : rd1, ed);
        end
      end
    end
    rst = 0;
    idle(RL + 2);
  endtask

  initial begin
    rst = 1; req = 2'b00; we = 2'b00;
    addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
    m_ack = '0; m_we = 0; m_re = 0; m_wa = '0; m_ra = '0; m_din = '0; m_last = 1;
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = '0;
      m_known[i] = 0;
    end
    test_reset();
    test_single_write();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
